game_flow_controller: RTL
=========================

Name: game_flow_controller

Overview:
- Top-level game sequencer for PacMan.
- Owns game_state, which drives the renderer and the character controllers.
- Gates and resets the player and ghost controllers, and tracks lives, score, remaining dots and the frightened timer.
- Consumes event pulses from player/tilemap logic and ghost-overlap levels. All timing is counted in frame ticks (tick = one 100 Hz character-update strobe).

Parameters:
- TOTAL_DOTS, 240, dots (small + big) per level; dots_left reload value.
- INIT_LIVES, 3, lives loaded on game start (1..7).
- READY_TICKS, 200, ticks spent in READY before play.
- DYING_TICKS, 150, ticks spent in DYING.
- WON_TICKS, 300, ticks spent in WON before the next level.
- FRIGHT_TICKS, 600, frightened duration in ticks.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high; clears everything to IDLE.
- tick  in  1  one-clk strobe per frame; all timers count only on tick.
- start  in  1  synchronized start button; acted on at its rising edge (internal edge detect).
- dot_eaten  in  1  one-clk pulse, small dot consumed.
- big_dot_eaten  in  1  one-clk pulse, big dot consumed.
- ghost_overlap  in  4  level; bit i = player overlaps ghost i.
- game_state  out  3  0 IDLE, 1 READY, 2 PLAYING, 3 DYING, 4 WON, 5 GAME_OVER.
- chars_run  out  1  1 only in PLAYING; character controllers advance only when high.
- chars_reset  out  1  one-clk pulse on every entry to READY.
- frightened  out  1  fright timer nonzero.
- fright_ending  out  1  frightened and timer <= FRIGHT_TICKS/4 (for ghost flashing).
- ghost_eaten  out  4  ghosts eaten during the current fright window.
- lives  out  3  remaining lives.
- score  out  16  binary score, saturating at 65535.
- dots_left  out  9  dots remaining in the current level.

Behaviour:
- Reset: all outputs and internal counters are 0; state IDLE; dots_left=TOTAL_DOTS; chain multiplier = 200. Reset mid-operation aborts immediately, with no pulses emitted.
- IDLE and GAME_OVER, on start rise: go to READY; lives=INIT_LIVES, score=0, dots_left=TOTAL_DOTS, chars_reset pulses.
- READY: counter counts READY_TICKS ticks, then PLAYING. Game events are ignored in READY.
- PLAYING, dots and score:
  - dot_eaten: +10.
  - big_dot_eaten: +50.
  - Each dot pulse decrements dots_left. Both pulses in the same cycle decrement by 2 and add 60. dots_left never goes below 0.
- PLAYING, big dot: fright timer = FRIGHT_TICKS (retrigger reloads it), ghost_eaten cleared, chain reset to 200.
- PLAYING, overlap handling, evaluated per clk:
  - Let live = ghost_overlap & ~ghost_eaten.
  - If frightened and live != 0: eat the lowest-index live ghost only. Set its ghost_eaten bit, add the chain value, then double the chain (200/400/800/1600, capped at 1600). Remaining overlaps are handled on following cycles because the inputs are levels.
  - If not frightened and live != 0: go to DYING.
- PLAYING, end of level: when dots_left==0 (including the cycle it reaches 0), go to WON. Win takes priority over death in the same cycle.
- Fright timer: decrements on tick only while in PLAYING (frozen otherwise). When it reaches 0: frightened=0, ghost_eaten cleared, chain=200. Entering DYING or WON clears the timer, ghost_eaten and chain.
- DYING: after DYING_TICKS ticks:
  - If lives==1: lives=0, go to GAME_OVER.
  - Otherwise: lives-1, go to READY (chars_reset pulses; dots_left is kept).
- WON: after WON_TICKS ticks, go to READY; dots_left=TOTAL_DOTS; score and lives kept; chars_reset pulses.
- Score addition saturates at 65535, with no wrap.
- Timers: tick and a state change coincide → the new state's counter starts at 0; that tick is not counted.

Optional Feature:
- EXTRA_LIFE_EN defined: the first time score crosses from <10000 to >=10000 in a game, lives increments by 1 (capped at 7). A one-shot flag records this and is cleared on game start.
- Undefined: lives only decrement; no flag register exists.

Test Plan:
- TOTAL_DOTS=4, READY_TICKS=3: reset, start rise, 3 ticks → chars_reset pulse once, then game_state=2, chars_run=1, lives=3, score=0.
- In PLAYING: dot_eaten and big_dot_eaten in the same cycle, then 2 dot_eaten → score=80, dots_left=0, state=4 on the cycle dots_left hits 0.
- Big dot (FRIGHT_TICKS=8), then ghost_overlap=4'b0110 held → ghost 1 eaten (+200), next cycle ghost 2 eaten (+400), ghost_eaten=0110, no DYING. After 8 ticks: frightened=0, ghost_eaten=0. fright_ending is high for ticks 7-8.
- Not frightened, ghost_overlap=0001 → DYING. After DYING_TICKS: lives 3→2, READY, dots_left unchanged. Repeat until lives=1 and die again → GAME_OVER, lives=0. Start rise → READY, lives=3, score=0.
- Last dot and a deadly overlap in the same cycle → WON, not DYING; lives unchanged.
- Preload score near 65530, dot_eaten → score=65535. Assert reset mid-DYING → IDLE, all outputs 0 within the same cycle.

Source files
------------

// File: rtl/game_flow_controller.sv
`default_nettype none
// =============================================================================
// Module      : game_flow_controller
// Description : PacMan game sequencer: state, lives, score, dots, fright timer.
//               Optional EXTRA_LIFE_EN: one bonus life when score first
//               reaches 10000 in a game.
// Revision    : 1.0
// =============================================================================
module game_flow_controller #(
   parameter int TOTAL_DOTS   = 240,
   parameter int INIT_LIVES   = 3,
   parameter int READY_TICKS  = 200,
   parameter int DYING_TICKS  = 150,
   parameter int WON_TICKS    = 300,
   parameter int FRIGHT_TICKS = 600
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tick,
   input  logic        start,
   input  logic        dot_eaten,
   input  logic        big_dot_eaten,
   input  logic [3:0]  ghost_overlap,
   output logic [2:0]  game_state,
   output logic        chars_run,
   output logic        chars_reset,
   output logic        frightened,
   output logic        fright_ending,
   output logic [3:0]  ghost_eaten,
   output logic [2:0]  lives,
   output logic [15:0] score,
   output logic [8:0]  dots_left
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_READY     = 3'd1,
      S_PLAYING   = 3'd2,
      S_DYING     = 3'd3,
      S_WON       = 3'd4,
      S_GAME_OVER = 3'd5
   } state_t;

   localparam int CNT_MAX_RD = (READY_TICKS > DYING_TICKS) ? READY_TICKS : DYING_TICKS;
   localparam int CNT_MAX    = (CNT_MAX_RD > WON_TICKS) ? CNT_MAX_RD : WON_TICKS;
   localparam int CNT_W      = $clog2(CNT_MAX + 1);
   localparam int FW         = $clog2(FRIGHT_TICKS + 1);
   localparam logic [10:0] CHAIN_BASE = 11'd200;
   localparam logic [10:0] CHAIN_MAX  = 11'd1600;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [FW-1:0]     fright_q, fright_d;
   logic [3:0]        eaten_q, eaten_d;
   logic [10:0]       chain_q, chain_d;
   logic [2:0]        lives_q, lives_d;
   logic [15:0]       score_q, score_d;
   logic [8:0]        dots_q, dots_d;
   logic              start_q, start_d;
   logic              chars_reset_q, chars_reset_d;
`ifdef EXTRA_LIFE_EN
   logic              bonus_q, bonus_d;
`endif

   logic              start_rise;
   logic [3:0]        live;
   logic [3:0]        eat_sel;
   logic [1:0]        dot_dec;
   logic [10:0]       points;
   logic [16:0]       score_sum;
   logic              died;

   assign start_rise = start & ~start_q;
   assign live       = ghost_overlap & ~eaten_q;
   assign dot_dec    = {1'b0, dot_eaten} + {1'b0, big_dot_eaten};

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      fright_d      = fright_q;
      eaten_d       = eaten_q;
      chain_d       = chain_q;
      lives_d       = lives_q;
      score_d       = score_q;
      dots_d        = dots_q;
      start_d       = start;
      chars_reset_d = 1'b0;
      points        = '0;
      score_sum     = '0;
      died          = 1'b0;
      eat_sel       = '0;
`ifdef EXTRA_LIFE_EN
      bonus_d       = bonus_q;
`endif
      // Descending scan so the lowest-index live ghost is the last writer.
      for (int i = 3; i >= 0; i--) begin
         if (live[i]) eat_sel = 4'(1 << i);
      end

      case (state_q)
         S_IDLE, S_GAME_OVER: begin
            if (start_rise) begin
               state_d       = S_READY;
               cnt_d         = '0;
               lives_d       = 3'(INIT_LIVES);
               score_d       = '0;
               dots_d        = 9'(TOTAL_DOTS);
               chars_reset_d = 1'b1;
`ifdef EXTRA_LIFE_EN
               bonus_d       = 1'b0;
`endif
            end
         end

         S_READY: begin
            if (tick) begin
               if (cnt_q == CNT_W'(READY_TICKS - 1)) begin
                  state_d = S_PLAYING;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         S_PLAYING: begin
            points = (dot_eaten ? 11'd10 : 11'd0) + (big_dot_eaten ? 11'd50 : 11'd0);
            dots_d = (dots_q > 9'(dot_dec)) ? dots_q - 9'(dot_dec) : 9'd0;
            if (|live) begin
               if (fright_q != '0) begin
                  points  = points + chain_q;
                  eaten_d = eaten_q | eat_sel;
                  chain_d = (chain_q >= (CHAIN_MAX >> 1)) ? CHAIN_MAX : (chain_q << 1);
               end else begin
                  died = 1'b1;
               end
            end
            score_sum = {1'b0, score_q} + 17'(points);
            score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
`ifdef EXTRA_LIFE_EN
            if (!bonus_q && (score_q < 16'd10000) && (score_d >= 16'd10000)) begin
               bonus_d = 1'b1;
               if (lives_q != 3'd7) lives_d = lives_q + 1'b1;
            end
`endif
            // A fresh big dot overrides whatever the eat/expiry logic did.
            if (big_dot_eaten) begin
               fright_d = FW'(FRIGHT_TICKS);
               eaten_d  = '0;
               chain_d  = CHAIN_BASE;
            end else if (tick && (fright_q != '0)) begin
               fright_d = fright_q - 1'b1;
               if (fright_q == FW'(1)) begin
                  eaten_d = '0;
                  chain_d = CHAIN_BASE;
               end
            end
            if ((dots_d == 9'd0) || died) begin
               state_d  = (dots_d == 9'd0) ? S_WON : S_DYING;
               cnt_d    = '0;
               fright_d = '0;
               eaten_d  = '0;
               chain_d  = CHAIN_BASE;
            end
         end

         S_DYING: begin
            if (tick) begin
               if (cnt_q == CNT_W'(DYING_TICKS - 1)) begin
                  cnt_d = '0;
                  if (lives_q <= 3'd1) begin
                     lives_d = 3'd0;
                     state_d = S_GAME_OVER;
                  end else begin
                     lives_d       = lives_q - 1'b1;
                     state_d       = S_READY;
                     chars_reset_d = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         S_WON: begin
            if (tick) begin
               if (cnt_q == CNT_W'(WON_TICKS - 1)) begin
                  cnt_d         = '0;
                  state_d       = S_READY;
                  dots_d        = 9'(TOTAL_DOTS);
                  chars_reset_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         fright_q      <= '0;
         eaten_q       <= '0;
         chain_q       <= CHAIN_BASE;
         lives_q       <= '0;
         score_q       <= '0;
         dots_q        <= 9'(TOTAL_DOTS);
         start_q       <= 1'b0;
         chars_reset_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         fright_q      <= fright_d;
         eaten_q       <= eaten_d;
         chain_q       <= chain_d;
         lives_q       <= lives_d;
         score_q       <= score_d;
         dots_q        <= dots_d;
         start_q       <= start_d;
         chars_reset_q <= chars_reset_d;
      end
   end

`ifdef EXTRA_LIFE_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) bonus_q <= 1'b0;
      else       bonus_q <= bonus_d;
   end
`endif

   assign game_state    = state_q;
   assign chars_run     = (state_q == S_PLAYING);
   assign chars_reset   = chars_reset_q;
   assign frightened    = (fright_q != '0);
   assign fright_ending = frightened && (fright_q <= FW'(FRIGHT_TICKS / 4));
   assign ghost_eaten   = eaten_q;
   assign lives         = lives_q;
   assign score         = score_q;
   assign dots_left     = dots_q;

endmodule
`default_nettype wire
